// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pkg
//  Purpose  : Shared types and defaults for the multi-cycle controller:
//             stage enumeration, datapath width and reset fetch address.
//  Revision : 1.0  initial release
// ============================================================================
package mc_pkg;

  // Default datapath / address width
  localparam int XLEN_DEFAULT = 32;

  // Default width of the retired-instruction counter
  localparam int CNT_W_DEFAULT = 32;

  // Default first fetch address after reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  // Pipeline stage encoding; the values are visible on the state port
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } mc_state_e;

  // An instruction touches the data port when it is a load or a store
  function automatic logic is_mem_op(input logic is_load, input logic is_store);
    return is_load | is_store;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pc_reg
//  Purpose  : Program counter register with reset value and next-pc select
//             (sequential pc+4 or taken-branch target).
//  Revision : 1.0  initial release
// ============================================================================
module mc_pc_reg
  import mc_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            advance,    // one-cycle strobe in the write-back stage
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // Next pc: hold, or on retire take the branch target or step by one word
  always_comb begin
    pc_d = pc_q;
    if (advance) begin
      // pc+4 wraps naturally at 2^XLEN
      pc_d = br_taken ? br_target : (pc_q + XLEN'(4));
    end
  end

  // PC state, asynchronously reset to the boot address
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl
//  Purpose  : Multi-cycle processor controller. Sequences each instruction
//             through IF -> ID -> EXE -> (MEM) -> WB, owns the instruction
//             and data request ports, latches EXE results and counts retires.
//  Config   : MC_CTRL_SKIP_MEM_EN - when defined, non-memory instructions
//             bypass MEM (EXE -> WB). When undefined every instruction visits
//             MEM; non-memory ones spend one quiet cycle there.
//  Revision : 1.0  initial release
// ============================================================================
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  // instruction port
  output logic             inst_req,
  output logic [XLEN-1:0]  inst_addr,
  input  logic [31:0]      inst_rdata,
  input  logic             inst_data_ok,
  // decode attributes of ir
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_gr_we,
  // execute results
  input  logic [XLEN-1:0]  ex_result,
  input  logic             ex_br_taken,
  input  logic [XLEN-1:0]  ex_br_target,
  input  logic [XLEN-1:0]  ex_rkd,
  // data port
  output logic             data_req,
  output logic             data_we,
  output logic [XLEN-1:0]  data_addr,
  output logic [XLEN-1:0]  data_wdata,
  input  logic [XLEN-1:0]  data_rdata,
  input  logic             data_data_ok,
  // architectural / status outputs
  output logic [31:0]      ir,
  output logic [XLEN-1:0]  pc,
  output logic [2:0]       state,
  output logic             rf_we,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [CNT_W-1:0] retire_cnt
);

`ifdef MC_CTRL_SKIP_MEM_EN
  localparam logic SKIP_MEM = 1'b1;
`else
  localparam logic SKIP_MEM = 1'b0;
`endif

  mc_state_e        state_d,      state_q;
  logic [31:0]      ir_d,         ir_q;
  logic [XLEN-1:0]  res_d,        res_q;
  logic [XLEN-1:0]  st_d,         st_q;
  logic             br_d,         br_q;
  logic [XLEN-1:0]  tgt_d,        tgt_q;
  logic [CNT_W-1:0] retire_cnt_d, retire_cnt_q;

  logic             mem_op;
  logic             in_wb;

  assign mem_op = is_mem_op(dec_is_load, dec_is_store);
  assign in_wb  = (state_q == S_WB);

  // Stage sequencing and datapath latches; handshakes outside their own stage are ignored
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    res_d        = res_q;
    st_d         = st_q;
    br_d         = br_q;
    tgt_d        = tgt_q;
    retire_cnt_d = retire_cnt_q;

    case (state_q)
      S_IF: begin
        if (inst_data_ok) begin
          ir_d    = inst_rdata;
          state_d = S_ID;
        end
      end

      S_ID: begin
        state_d = S_EXE;
      end

      S_EXE: begin
        res_d   = ex_result;
        st_d    = ex_rkd;
        br_d    = ex_br_taken;
        tgt_d   = ex_br_target;
        state_d = (mem_op || !SKIP_MEM) ? S_MEM : S_WB;
      end

      S_MEM: begin
        if (!mem_op) begin
          // Non-memory instruction passing through: one quiet cycle
          state_d = S_WB;
        end else if (data_data_ok) begin
          if (dec_is_load) begin
            res_d = data_rdata;
          end
          state_d = S_WB;
        end
      end

      S_WB: begin
        retire_cnt_d = retire_cnt_q + CNT_W'(1);
        state_d      = S_IF;
      end

      // Illegal encodings recover to fetch without side effects
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  // Controller state; reset aborts any in-flight instruction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IF;
      ir_q         <= '0;
      res_q        <= '0;
      st_q         <= '0;
      br_q         <= 1'b0;
      tgt_q        <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      res_q        <= res_d;
      st_q         <= st_d;
      br_q         <= br_d;
      tgt_q        <= tgt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Program counter advances only on retirement
  mc_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .resetn    (resetn),
    .advance   (in_wb),
    .br_taken  (br_q),
    .br_target (tgt_q),
    .pc        (pc)
  );

  // Fetch stays quiet while reset is held even though the state already reads IF
  assign inst_req   = resetn & (state_q == S_IF);
  assign inst_addr  = pc;

  // Data port is driven only by loads and stores sitting in MEM
  assign data_req   = (state_q == S_MEM) & mem_op;
  assign data_we    = data_req & dec_is_store;
  assign data_addr  = res_q;
  assign data_wdata = st_q;

  // Register-file write happens in the single WB cycle
  assign rf_we      = in_wb & dec_gr_we;
  assign rf_wdata   = res_q;

  assign ir         = ir_q;
  assign state      = state_q;
  assign retire_cnt = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl
//  Purpose  : Self-checking bench for mc_ctrl. Each instruction is described
//             as a transaction; the expected per-cycle stage sequence is built
//             from the latency rules and the architectural effects (pc,
//             retire count, write-back data) are kept in a small model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

  localparam int          XLEN  = 32;
  localparam int          CNT_W = 4;
  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_EXE = 2;
  localparam int ST_MEM = 3;
  localparam int ST_WB  = 4;

`ifdef MC_CTRL_SKIP_MEM_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic             clk;
  logic             resetn;
  logic             inst_req;
  logic [XLEN-1:0]  inst_addr;
  logic [31:0]      inst_rdata;
  logic             inst_data_ok;
  logic             dec_is_load;
  logic             dec_is_store;
  logic             dec_gr_we;
  logic [XLEN-1:0]  ex_result;
  logic             ex_br_taken;
  logic [XLEN-1:0]  ex_br_target;
  logic [XLEN-1:0]  ex_rkd;
  logic             data_req;
  logic             data_we;
  logic [XLEN-1:0]  data_addr;
  logic [XLEN-1:0]  data_wdata;
  logic [XLEN-1:0]  data_rdata;
  logic             data_data_ok;
  logic [31:0]      ir;
  logic [XLEN-1:0]  pc;
  logic [2:0]       dut_state;
  logic             rf_we;
  logic [XLEN-1:0]  rf_wdata;
  logic [CNT_W-1:0] retire_cnt;

  mc_ctrl #(
    .XLEN     (XLEN),
    .RESET_PC (RST_PC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .dec_is_load  (dec_is_load),
    .dec_is_store (dec_is_store),
    .dec_gr_we    (dec_gr_we),
    .ex_result    (ex_result),
    .ex_br_taken  (ex_br_taken),
    .ex_br_target (ex_br_target),
    .ex_rkd       (ex_rkd),
    .data_req     (data_req),
    .data_we      (data_we),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_data_ok (data_data_ok),
    .ir           (ir),
    .pc           (pc),
    .state        (dut_state),
    .rf_we        (rf_we),
    .rf_wdata     (rf_wdata),
    .retire_cnt   (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Architectural model: committed pc and retire count
  logic [31:0] m_pc;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Runs one instruction; entered and left at 1 time unit after a rising edge.
  task automatic run_instr(input bit ld, input bit st, input bit we, input bit br,
                           input logic [31:0] res, input logic [31:0] rkd,
                           input logic [31:0] tgt, input logic [31:0] rdata,
                           input logic [31:0] word, input int fwait, input int mwait,
                           input bit abort);
    int          tl[$];
    bit          mem;
    bit          last;
    int          s;
    int          nreq;
    logic [31:0] exp_wd;
    mem    = ld | st;
    nreq   = 0;
    exp_wd = ld ? rdata : res;

    // Expected stage for every cycle of this instruction
    for (int i = 0; i <= fwait; i++) tl.push_back(ST_IF);
    tl.push_back(ST_ID);
    tl.push_back(ST_EXE);
    if (mem) begin
      for (int i = 0; i <= mwait; i++) tl.push_back(ST_MEM);
    end else if (!SKIP) begin
      tl.push_back(ST_MEM);
    end
    tl.push_back(ST_WB);

    dec_is_load  = ld;
    dec_is_store = st;
    dec_gr_we    = we;

    for (int idx = 0; idx < tl.size(); idx++) begin
      s    = tl[idx];
      last = (idx + 1 >= tl.size()) || (tl[idx+1] != s);

      // Handshakes outside their stage are randomised to prove they are ignored
      inst_data_ok = (s == ST_IF) ? last : 1'($urandom_range(0, 1));
      inst_rdata   = (s == ST_IF && last) ? word : $urandom;
      ex_result    = (s == ST_EXE) ? res : $urandom;
      ex_rkd       = (s == ST_EXE) ? rkd : $urandom;
      ex_br_taken  = (s == ST_EXE) ? br  : 1'($urandom_range(0, 1));
      ex_br_target = (s == ST_EXE) ? tgt : $urandom;
      data_data_ok = (s == ST_MEM && mem) ? last : 1'($urandom_range(0, 1));
      data_rdata   = (s == ST_MEM && mem && last) ? rdata : $urandom;

      if (abort && s == ST_MEM) begin
        #2 resetn = 1'b0;
        #1;
        check_eq("abort_state",    dut_state, ST_IF);
        check_eq("abort_data_req", data_req,  0);
        check_eq("abort_rf_we",    rf_we,     0);
        check_eq("abort_inst_req", inst_req,  0);
        check_eq("abort_pc",       pc,        RST_PC);
        check_eq("abort_cnt",      retire_cnt, 0);
        m_pc  = RST_PC;
        m_cnt = 0;
        @(posedge clk);
        #1;
        check_eq("abort_hold_rf_we", rf_we, 0);
        resetn = 1'b1;
        return;
      end

      @(negedge clk);
      check_eq("state",    dut_state, s);
      check_eq("inst_req", inst_req,  (s == ST_IF));
      check_eq("data_req", data_req,  (s == ST_MEM && mem));
      check_eq("rf_we",    rf_we,     (s == ST_WB && we));
      check_eq("pc",       pc,        m_pc);
      check_eq("cnt",      retire_cnt, m_cnt);
      if (s == ST_IF) check_eq("inst_addr", inst_addr, m_pc);
      else            check_eq("ir",        ir,        word);
      if (data_req) nreq++;
      if (s == ST_MEM && mem) begin
        check_eq("data_we",    data_we,    st);
        check_eq("data_addr",  data_addr,  res);
        check_eq("data_wdata", data_wdata, rkd);
      end
      if (s == ST_WB) begin
        if (we) check_eq("rf_wdata", rf_wdata, exp_wd);
        m_pc  = br ? tgt : (m_pc + 32'd4);
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      @(posedge clk);
      #1;
    end
    check_eq("dreq_cycles", nreq, mem ? (mwait + 1) : 0);
  endtask

  initial begin
    int          kind;
    bit          r_ld, r_st, r_we, r_br;
    logic [31:0] r_tgt;

    resetn       = 1'b0;
    inst_rdata   = '0;
    inst_data_ok = 1'b0;
    dec_is_load  = 1'b0;
    dec_is_store = 1'b0;
    dec_gr_we    = 1'b0;
    ex_result    = '0;
    ex_br_taken  = 1'b0;
    ex_br_target = '0;
    ex_rkd       = '0;
    data_rdata   = '0;
    data_data_ok = 1'b1;
    m_pc         = RST_PC;
    m_cnt        = 0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state",    dut_state, ST_IF);
    check_eq("rst_pc",       pc,        RST_PC);
    check_eq("rst_ir",       ir,        0);
    check_eq("rst_cnt",      retire_cnt, 0);
    check_eq("rst_inst_req", inst_req,  0);
    check_eq("rst_data_req", data_req,  0);
    check_eq("rst_rf_we",    rf_we,     0);
    resetn = 1'b1;

    // add.w with zero-wait fetch
    run_instr(0, 0, 1, 0, 32'h0000_0011, 32'h0, 32'h0, 32'h0, 32'h0010_1c85, 0, 0, 0);
    check_eq("add_pc",  pc,         32'h1c00_0004);
    check_eq("add_cnt", retire_cnt, 1);

    // ld.w with three data wait cycles
    run_instr(1, 0, 1, 0, 32'h0000_0100, 32'h5555_aaaa, 32'h0, 32'hdead_beef, 32'h2880_0085, 0, 3, 0);

    // st.w, no register write
    run_instr(0, 1, 0, 0, 32'h0000_0200, 32'h1234_5678, 32'h0, 32'h0, 32'h2980_0085, 1, 2, 0);

    // Taken branch
    run_instr(0, 0, 0, 1, 32'h0, 32'h0, 32'h1c00_0040, 32'h0, 32'h5800_0000, 0, 0, 0);
    check_eq("br_inst_addr", inst_addr, 32'h1c00_0040);

    // Jump to the top of the address space, then wrap on pc+4
    run_instr(0, 0, 0, 1, 32'h0, 32'h0, 32'hffff_fffc, 32'h0, 32'h5800_0004, 0, 0, 0);
    run_instr(0, 0, 1, 0, 32'h0000_0007, 32'h0, 32'h0, 32'h0, 32'h0010_1c86, 2, 0, 0);
    check_eq("wrap_pc", pc, 32'h0);

    // Reset arriving while a load waits in MEM
    run_instr(1, 0, 1, 0, 32'h0000_0300, 32'h0, 32'h0, 32'hcafe_f00d, 32'h2880_0086, 0, 2, 1);

    // Randomised instruction stream; more than 2^CNT_W retires exercises the counter wrap
    for (int n = 0; n < 40; n++) begin
      kind  = $urandom_range(0, 3);
      r_ld  = (kind == 1);
      r_st  = (kind == 2);
      r_br  = (kind == 3) && ($urandom_range(0, 1) == 1);
      r_we  = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      r_tgt = $urandom & 32'hffff_fffc;
      run_instr(r_ld, r_st, r_we, r_br, $urandom, $urandom, r_tgt, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter XLEN, default 32, datapath and address width.
REQ-002 Parameter RESET_PC, default 32'h1c000000, first fetch address after reset.
REQ-003 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 inst_req  out  1  instruction fetch request.
REQ-007 inst_addr  out  XLEN  fetch address.
REQ-008 inst_rdata  in  32  fetched instruction.
REQ-009 inst_data_ok  in  1  fetch data valid.
REQ-010 dec_is_load / dec_is_store / dec_gr_we  in  1 each  decode attributes of ir.
REQ-011 ex_result  in  XLEN  ALU result; ex_br_taken  in  1; ex_br_target  in  XLEN.
REQ-012 data_req  out  1; data_we  out  1; data_addr  out  XLEN; data_wdata  out  XLEN.
REQ-013 data_rdata  in  XLEN; data_data_ok  in  1  data access complete.
REQ-014 ex_rkd  in  XLEN  store data captured in EXE.
REQ-015 ir  out  32; pc  out  XLEN; state  out  3  current stage.
REQ-016 rf_we  out  1; rf_wdata  out  XLEN; retire_cnt  out  CNT_W.

Function
REQ-017 States IF=0, ID=1, EXE=2, MEM=3, WB=4; state encodings outside 0-4 SHALL return to IF next cycle.
REQ-018 IF: inst_req=1, inst_addr=pc held stable; on inst_data_ok ir<=inst_rdata, go ID; else stay IF.
REQ-019 ID: single cycle, unconditionally go EXE.
REQ-020 EXE: single cycle; latch res_q<=ex_result, st_q<=ex_rkd, br_q<=ex_br_taken, tgt_q<=ex_br_target.
REQ-021 EXE exit: to MEM if dec_is_load|dec_is_store, else to WB (subject to REQ-029).
REQ-022 MEM: data_req=1, data_addr=res_q, data_wdata=st_q, data_we=dec_is_store, held until data_data_ok; then go WB.
REQ-023 MEM completion with dec_is_load: res_q<=data_rdata on the data_data_ok cycle.
REQ-024 WB: single cycle; rf_we=dec_gr_we, rf_wdata=res_q; pc<=br_q ? tgt_q : pc+4 (mod 2^XLEN); retire_cnt+1 (wraps at 2^CNT_W); go IF.
REQ-025 inst_data_ok outside IF and data_data_ok outside MEM SHALL be ignored.
REQ-026 inst_req, data_req, rf_we SHALL be 0 in every state other than the one owning them.
REQ-027 Latency: non-memory instruction with zero-wait fetch = 4 cycles (IF..WB); memory instruction with zero-wait SRAM = 5 cycles.

Reset
REQ-028 resetn low asynchronously forces state=IF, pc=RESET_PC, ir=0, res_q/st_q/tgt_q=0, br_q=0, retire_cnt=0, all requests and rf_we=0; in-flight instruction aborted without register write.

Configuration
REQ-029 Macro MC_CTRL_SKIP_MEM_EN defined: non-memory instructions go EXE->WB (REQ-021); undefined: every instruction passes through MEM, which for non-memory instructions asserts no data_req and lasts one cycle.

Structure
REQ-030 Shared package mc_pkg holds the state enum, XLEN default and RESET_PC default.
REQ-031 One sub-module mc_pc_reg (pc register with reset value and next-pc mux); FSM and latches stay in mc_ctrl.

Verification
REQ-032 Reset release, inst_data_ok tied 1, add.w in ir -> inst_addr=0x1c000000, rf_we pulse at cycle 4 (MACRO on) / 5 (off), pc=0x1c000004, retire_cnt=1.
REQ-033 ld.w, res=0x100, data_data_ok after 3 wait cycles, data_rdata=0xdeadbeef -> data_req high 4 cycles, rf_wdata=0xdeadbeef.
REQ-034 st.w, ex_rkd=0x12345678 -> data_we=1, data_wdata=0x12345678, rf_we stays 0.
REQ-035 Branch taken, tgt=0x1c000040 -> next inst_addr=0x1c000040; pc=0xfffffffc not taken -> wraps to 0.
REQ-036 resetn low during MEM -> state=IF, data_req=0 same cycle, no rf_we, pc=RESET_PC.
REQ-037 CNT_W=4, 16 retires -> retire_cnt wraps to 0; spurious data_data_ok in IF -> no state change.
